// File: rtl/ctrl_pkg.sv
// Shared decode constants for control_unit_pipe.
// Holds the opcode map, the memory size codes, the halt states and the control-word layout.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LHU   = 6'h22;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LWU   = 6'h24;
    localparam logic [5:0] OP_LBU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HALT  = 6'h3f;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam logic [1:0] MS_BYTE  = 2'b00;
    localparam logic [1:0] MS_HALF  = 2'b01;
    localparam logic [1:0] MS_WORD  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } halt_state_t;

    localparam int CW_REG_DEST   = 0;
    localparam int CW_ALU_SRC    = 1;
    localparam int CW_MEM_READ   = 2;
    localparam int CW_MEM_WRITE  = 3;
    localparam int CW_REG_WRITE  = 4;
    localparam int CW_MEM_TO_REG = 5;
    localparam int CW_BRANCH     = 6;
    localparam int CW_MEM_SIZE   = 8;
    localparam int CW_MEM_UNS    = 10;
    localparam int CW_JR_JALR    = 11;
    localparam int CW_JUMP       = 12;
    localparam int CW_LINK       = 13;
    localparam int CW_ILLEGAL    = 14;
    localparam int CW_HALT       = 15;
    localparam int CW_W          = 16;

    function automatic logic [1:0] mem_size_of(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return MS_BYTE;
            OP_LH, OP_LHU, OP_SH: return MS_HALF;
            default:              return MS_WORD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_pipe_if.sv
// IF/ID-side inputs and ID/EX-side control outputs of control_unit_pipe.
// master drives the instruction side, slave is the control unit.
interface control_unit_pipe_if #(
    parameter int NB_OPCODE = 6,
    parameter int NB_FUNCT  = 6
);
    logic                 i_enable;
    logic                 i_valid;
    logic                 i_stall;
    logic                 i_flush;
    logic [NB_OPCODE-1:0] i_opcode;
    logic [NB_FUNCT-1:0]  i_funct;

    logic                 o_valid;
    logic                 o_reg_dest;
    logic                 o_alu_src;
    logic                 o_mem_read;
    logic                 o_mem_write;
    logic                 o_reg_write;
    logic                 o_mem_to_reg;
    logic [NB_OPCODE-1:0] o_alu_op;
    logic [1:0]           o_branch;
    logic [1:0]           o_mem_size;
    logic                 o_mem_unsigned;
    logic                 o_jr_jalr;
    logic                 o_jump;
    logic                 o_link;
    logic                 o_illegal;
    logic                 o_halt;
    logic                 o_halted;

    modport master (
        output i_enable, i_valid, i_stall, i_flush,
        output i_opcode, i_funct,
        input  o_valid, o_reg_dest, o_alu_src,
        input  o_mem_read, o_mem_write, o_reg_write,
        input  o_mem_to_reg, o_alu_op, o_branch,
        input  o_mem_size, o_mem_unsigned, o_jr_jalr,
        input  o_jump, o_link, o_illegal,
        input  o_halt, o_halted
    );

    modport slave (
        input  i_enable, i_valid, i_stall, i_flush,
        input  i_opcode, i_funct,
        output o_valid, o_reg_dest, o_alu_src,
        output o_mem_read, o_mem_write, o_reg_write,
        output o_mem_to_reg, o_alu_op, o_branch,
        output o_mem_size, o_mem_unsigned, o_jr_jalr,
        output o_jump, o_link, o_illegal,
        output o_halt, o_halted
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decode into the flat control word.
// J/JAL decode only when CTRL_JUMP_EN is defined; otherwise they are illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int NB_OPCODE = 6,
    parameter int NB_FUNCT  = 6
) (
    input  logic [NB_OPCODE-1:0] opcode,
    input  logic [NB_FUNCT-1:0]  funct,
    output logic [CW_W-1:0]      cw,
    output logic [NB_OPCODE-1:0] alu_op
);

    logic is_r;
    logic is_beq;
    logic is_bne;
    logic is_imm;
    logic is_load;
    logic is_store;
    logic is_halt;
    logic is_jr;
    logic is_jalr;
`ifdef CTRL_JUMP_EN
    logic is_j;
    logic is_jal;
`endif

    function automatic logic op_is(
        input logic [NB_OPCODE-1:0] op,
        input logic [5:0]           code
    );
        return op == NB_OPCODE'(code);
    endfunction

    assign is_r    = op_is(opcode, OP_RTYPE);
    assign is_beq  = op_is(opcode, OP_BEQ);
    assign is_bne  = op_is(opcode, OP_BNE);
    assign is_halt = op_is(opcode, OP_HALT);

    assign is_imm = op_is(opcode, OP_ADDI)
                  | op_is(opcode, OP_SLTI)
                  | op_is(opcode, OP_ANDI)
                  | op_is(opcode, OP_ORI)
                  | op_is(opcode, OP_XORI)
                  | op_is(opcode, OP_LUI);

    assign is_load = op_is(opcode, OP_LB)
                   | op_is(opcode, OP_LH)
                   | op_is(opcode, OP_LHU)
                   | op_is(opcode, OP_LW)
                   | op_is(opcode, OP_LWU)
                   | op_is(opcode, OP_LBU);

    assign is_store = op_is(opcode, OP_SB)
                    | op_is(opcode, OP_SH)
                    | op_is(opcode, OP_SW);

    assign is_jr   = funct == NB_FUNCT'(FN_JR);
    assign is_jalr = funct == NB_FUNCT'(FN_JALR);

`ifdef CTRL_JUMP_EN
    assign is_j   = op_is(opcode, OP_J);
    assign is_jal = op_is(opcode, OP_JAL);
`endif

    always_comb begin
        cw     = '0;
        alu_op = opcode;
        unique case (1'b1)
            is_r: begin
                alu_op            = '0;
                cw[CW_REG_DEST]   = 1'b1;
                cw[CW_REG_WRITE]  = !is_jr;
                cw[CW_JR_JALR]    = is_jr | is_jalr;
                cw[CW_LINK]       = is_jalr;
            end
            is_beq: cw[CW_BRANCH+:2] = 2'b01;
            is_bne: cw[CW_BRANCH+:2] = 2'b10;
            is_imm: begin
                cw[CW_ALU_SRC]   = 1'b1;
                cw[CW_REG_WRITE] = 1'b1;
            end
            is_load: begin
                cw[CW_ALU_SRC]     = 1'b1;
                cw[CW_MEM_READ]    = 1'b1;
                cw[CW_MEM_TO_REG]  = 1'b1;
                cw[CW_REG_WRITE]   = 1'b1;
                cw[CW_MEM_SIZE+:2] = mem_size_of(opcode[5:0]);
                cw[CW_MEM_UNS]     = op_is(opcode, OP_LHU)
                                   | op_is(opcode, OP_LWU)
                                   | op_is(opcode, OP_LBU);
            end
            is_store: begin
                cw[CW_ALU_SRC]     = 1'b1;
                cw[CW_MEM_WRITE]   = 1'b1;
                cw[CW_MEM_SIZE+:2] = mem_size_of(opcode[5:0]);
            end
            is_halt: begin
                alu_op      = '0;
                cw[CW_HALT] = 1'b1;
            end
`ifdef CTRL_JUMP_EN
            is_j: cw[CW_JUMP] = 1'b1;
            is_jal: begin
                cw[CW_JUMP]      = 1'b1;
                cw[CW_LINK]      = 1'b1;
                cw[CW_REG_WRITE] = 1'b1;
            end
`endif
            default: cw[CW_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit_pipe.sv
// Registered main control unit with ID/EX valid/stall/flush and HALT drain.
// Optional J/JAL support is enabled by defining CTRL_JUMP_EN.
module control_unit_pipe
    import ctrl_pkg::*;
#(
    parameter int NB_OPCODE    = 6,
    parameter int NB_FUNCT     = 6,
    parameter int DRAIN_CYCLES = 4
) (
    input logic               i_clock,
    input logic               i_reset,
    control_unit_pipe_if.slave bus
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [CW_W-1:0]      cw_dec;
    logic [NB_OPCODE-1:0] alu_op_dec;
    logic [CW_W-1:0]      cw_q;
    logic [NB_OPCODE-1:0] alu_op_q;
    logic                 valid_q;
    halt_state_t          state;
    halt_state_t          state_nxt;
    logic [3:0]           cnt;
    logic [3:0]           cnt_nxt;
    logic                 load;

    ctrl_decode #(
        .NB_OPCODE (NB_OPCODE),
        .NB_FUNCT  (NB_FUNCT)
    ) u_decode (
        .opcode (bus.i_opcode),
        .funct  (bus.i_funct),
        .cw     (cw_dec),
        .alu_op (alu_op_dec)
    );

    assign load = bus.i_enable && state == ST_RUN
               && !bus.i_flush && !bus.i_stall;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (bus.i_enable) begin
            unique case (state)
                ST_RUN: begin
                    if (load && bus.i_valid && cw_dec[CW_HALT]) begin
                        state_nxt = ST_DRAIN;
                        cnt_nxt   = DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == 4'd0) state_nxt = ST_HALTED;
                    else             cnt_nxt   = cnt - 4'd1;
                end
                default: state_nxt = ST_HALTED;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Once draining, nothing new enters and the HALT word self-clears.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid_q  <= 1'b0;
            cw_q     <= '0;
            alu_op_q <= '0;
        end else if (bus.i_enable) begin
            if (state != ST_RUN || bus.i_flush) begin
                valid_q  <= 1'b0;
                cw_q     <= '0;
                alu_op_q <= '0;
            end else if (!bus.i_stall) begin
                valid_q  <= bus.i_valid;
                cw_q     <= bus.i_valid ? cw_dec : '0;
                alu_op_q <= bus.i_valid ? alu_op_dec : '0;
            end
        end
    end

    assign bus.o_valid        = valid_q;
    assign bus.o_reg_dest     = cw_q[CW_REG_DEST];
    assign bus.o_alu_src      = cw_q[CW_ALU_SRC];
    assign bus.o_mem_read     = cw_q[CW_MEM_READ];
    assign bus.o_mem_write    = cw_q[CW_MEM_WRITE];
    assign bus.o_reg_write    = cw_q[CW_REG_WRITE];
    assign bus.o_mem_to_reg   = cw_q[CW_MEM_TO_REG];
    assign bus.o_alu_op       = alu_op_q;
    assign bus.o_branch       = cw_q[CW_BRANCH+:2];
    assign bus.o_mem_size     = cw_q[CW_MEM_SIZE+:2];
    assign bus.o_mem_unsigned = cw_q[CW_MEM_UNS];
    assign bus.o_jr_jalr      = cw_q[CW_JR_JALR];
    assign bus.o_link         = cw_q[CW_LINK];
    assign bus.o_illegal      = cw_q[CW_ILLEGAL];
    assign bus.o_halt         = cw_q[CW_HALT];
    assign bus.o_halted       = state == ST_HALTED;

`ifdef CTRL_JUMP_EN
    assign bus.o_jump = cw_q[CW_JUMP];
`else
    logic unused_jump;
    assign unused_jump = cw_q[CW_JUMP];
    assign bus.o_jump  = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed bench for control_unit_pipe: decode, stall/flush, freeze and halt drain.
// Expected words are hand-built field by field with mk().
module tb_control_unit_pipe;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    control_unit_pipe_if #(.NB_OPCODE(6), .NB_FUNCT(6)) bus ();

    control_unit_pipe #(
        .NB_OPCODE    (6),
        .NB_FUNCT     (6),
        .DRAIN_CYCLES (4)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] obs;
    assign obs = {bus.o_valid, bus.o_reg_dest, bus.o_alu_src,
                  bus.o_mem_read, bus.o_mem_write, bus.o_reg_write,
                  bus.o_mem_to_reg, bus.o_alu_op, bus.o_branch,
                  bus.o_mem_size, bus.o_mem_unsigned, bus.o_jr_jalr,
                  bus.o_jump, bus.o_link, bus.o_illegal,
                  bus.o_halt, bus.o_halted};

    function automatic logic [23:0] mk(
        input logic v,  input logic rd, input logic as,
        input logic mr, input logic mw, input logic rw,
        input logic m2r, input logic [5:0] aop,
        input logic [1:0] br, input logic [1:0] ms,
        input logic mu, input logic jr, input logic j,
        input logic lk, input logic il, input logic h,
        input logic hd
    );
        return {v, rd, as, mr, mw, rw, m2r, aop, br, ms,
                mu, jr, j, lk, il, h, hd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] e);
        total++;
        assert (obs === e) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, e);
    endtask

    task automatic drive(
        input logic v, input logic [5:0] op, input logic [5:0] fn
    );
        bus.i_valid  = v;
        bus.i_opcode = op;
        bus.i_funct  = fn;
    endtask

    logic [23:0] zero_w, lw_w, lbu_w, addi_w, halt_w, hd_w, j_w;

    initial begin
        passed = 0;
        total  = 0;
        zero_w = '0;
        lw_w   = mk(1,0,1,1,0,1,1,6'h23,2'b00,2'b11,0,0,0,0,0,0,0);
        lbu_w  = mk(1,0,1,1,0,1,1,6'h25,2'b00,2'b00,1,0,0,0,0,0,0);
        addi_w = mk(1,0,1,0,0,1,0,6'h08,2'b00,2'b00,0,0,0,0,0,0,0);
        halt_w = mk(1,0,0,0,0,0,0,6'h00,2'b00,2'b00,0,0,0,0,0,1,0);
        hd_w   = mk(0,0,0,0,0,0,0,6'h00,2'b00,2'b00,0,0,0,0,0,0,1);
`ifdef CTRL_JUMP_EN
        j_w    = mk(1,0,0,0,0,0,0,6'h02,2'b00,2'b00,0,0,1,0,0,0,0);
`else
        j_w    = mk(1,0,0,0,0,0,0,6'h02,2'b00,2'b00,0,0,0,0,1,0,0);
`endif

        rst          = 1'b1;
        bus.i_enable = 1'b1;
        bus.i_stall  = 1'b0;
        bus.i_flush  = 1'b0;
        drive(1, 6'h23, 6'h00);
        tick(); chk("reset1", zero_w);
        tick(); chk("reset2", zero_w);
        rst = 1'b0;
        tick(); chk("lw", lw_w);

        drive(1, 6'h00, 6'h09);
        tick();
        chk("jalr", mk(1,1,0,0,0,1,0,6'h00,2'b00,2'b00,0,1,0,1,0,0,0));
        drive(1, 6'h00, 6'h08);
        tick();
        chk("jr", mk(1,1,0,0,0,0,0,6'h00,2'b00,2'b00,0,1,0,0,0,0,0));

        drive(1, 6'h25, 6'h00);
        tick(); chk("lbu", lbu_w);
        bus.i_stall = 1'b1;
        drive(1, 6'h2b, 6'h00);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("stall_hold", lbu_w);
        end
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b1;
        tick(); chk("flush", zero_w);
        bus.i_flush = 1'b0;

        drive(1, 6'h3e, 6'h00);
        tick();
        chk("illegal_3e", mk(1,0,0,0,0,0,0,6'h3e,2'b00,2'b00,0,0,0,0,1,0,0));
        drive(1, 6'h02, 6'h00);
        tick(); chk("op_02", j_w);

        drive(0, 6'h23, 6'h00);
        tick(); chk("not_valid", zero_w);
        drive(1, 6'h29, 6'h00);
        tick();
        chk("sh", mk(1,0,1,0,1,0,0,6'h29,2'b00,2'b01,0,0,0,0,0,0,0));
        drive(1, 6'h04, 6'h00);
        tick();
        chk("beq", mk(1,0,0,0,0,0,0,6'h04,2'b01,2'b00,0,0,0,0,0,0,0));
        drive(1, 6'h05, 6'h00);
        tick();
        chk("bne", mk(1,0,0,0,0,0,0,6'h05,2'b10,2'b00,0,0,0,0,0,0,0));

        drive(1, 6'h08, 6'h00);
        tick(); chk("addi", addi_w);
        bus.i_enable = 1'b0;
        drive(1, 6'h23, 6'h00);
        tick(); chk("freeze_run", addi_w);
        bus.i_enable = 1'b1;

        drive(1, 6'h3f, 6'h00);
        bus.i_flush = 1'b1;
        tick(); chk("halt_flushed", zero_w);
        bus.i_flush = 1'b0;
        bus.i_stall = 1'b1;
        tick(); chk("halt_stalled", zero_w);
        bus.i_stall = 1'b0;
        tick(); chk("halt_pulse", halt_w);
        drive(1, 6'h08, 6'h00);
        tick(); chk("drain1", zero_w);
        bus.i_enable = 1'b0;
        tick(); chk("drain_frz1", zero_w);
        tick(); chk("drain_frz2", zero_w);
        bus.i_enable = 1'b1;
        tick(); chk("drain2", zero_w);
        tick(); chk("drain3", zero_w);
        tick(); chk("halted_rise", hd_w);
        tick(); chk("halted_stay", hd_w);
        bus.i_flush = 1'b1;
        tick(); chk("halted_flush", hd_w);
        bus.i_flush = 1'b0;

        rst = 1'b1;
        tick(); chk("reset_halted", zero_w);
        rst = 1'b0;
        drive(1, 6'h3f, 6'h00);
        tick(); chk("halt2_pulse", halt_w);
        tick(); chk("halt2_drain", zero_w);
        rst = 1'b1;
        tick(); chk("reset_drain", zero_w);
        rst = 1'b0;
        drive(1, 6'h23, 6'h00);
        tick(); chk("run_after_rst", lw_w);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
